// File: rtl/ramz_pkg.sv
// Shared constants and state encoding for the ramz buffer and its read-side sequencer.
package ramz_pkg;

    localparam int RAMZ_AW = 7;
    localparam int RAMZ_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ramz_reader_if.sv
// Output word stream of ramz_reader (valid/ready); RAMZ_READER_LAST_EN adds m_last.
interface ramz_reader_if
    import ramz_pkg::*;
#(
    parameter int DW = RAMZ_DW
);

    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
`ifdef RAMZ_READER_LAST_EN
    logic          m_last;
`endif

    modport master (
        output m_data,
        output m_valid,
`ifdef RAMZ_READER_LAST_EN
        output m_last,
`endif
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
`ifdef RAMZ_READER_LAST_EN
        input  m_last,
`endif
        output m_ready
    );

endinterface

// File: rtl/ramz_skid_fifo.sv
// Two-entry synchronous FIFO holding captured RAM words; flush empties it without touching storage.
module ramz_skid_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_wr;
    logic         do_rd;

    always_comb begin
        do_rd    = rd_en && (count != 2'd0);
        do_wr    = wr_en && ((count != 2'd2) || do_rd);
        rd_data  = mem[rd_ptr];
        rd_valid = (count != 2'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_wr} - {1'b0, do_rd};
        end
    end

endmodule

// File: rtl/ramz_reader.sv
// Read-side sequencer for the ramz 128x32 buffer: walks a wrapping address range into a valid/ready stream.
// Optional RAMZ_READER_LAST_EN adds a per-word m_last flag on the stream interface.
module ramz_reader
    import ramz_pkg::*;
#(
    parameter int AW = RAMZ_AW,
    parameter int DW = RAMZ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    ramz_reader_if.master m
);

`ifdef RAMZ_READER_LAST_EN
    localparam int FW = DW + 1;
`else
    localparam int FW = DW;
`endif

    state_t        state;
    logic [AW:0]   remaining;
    logic          inflight;
    logic          pop;
    logic          issue;
    logic          last_issue;
    logic          flush;
    logic          wr_en;
    logic          drain_exit;
    logic [1:0]    count;
    logic [FW-1:0] wr_data;
    logic [FW-1:0] rd_data;
    logic          rd_valid;
`ifdef RAMZ_READER_LAST_EN
    logic          inflight_last;
`endif

    // ram_addr always holds the address ramz samples at the next edge, so an
    // issue means "ramz captures ram_addr now" and the word lands one edge later.
    // A pop this cycle frees a slot, so it also counts as credit.
    always_comb begin
        pop        = rd_valid && m.m_ready;
        issue      = (state == ST_RUN) && !abort &&
                     ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
        last_issue = issue && (remaining == {{AW{1'b0}}, 1'b1});
        flush      = abort && (state != ST_IDLE);
        wr_en      = inflight && !flush;
        drain_exit = (state == ST_DRAIN) && !inflight &&
                     ((count == 2'd0) || ((count == 2'd1) && pop));
`ifdef RAMZ_READER_LAST_EN
        wr_data    = {inflight_last, ram_rdata};
`else
        wr_data    = ram_rdata;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
`ifdef RAMZ_READER_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                done     <= 1'b1;
                inflight <= 1'b0;
`ifdef RAMZ_READER_LAST_EN
                inflight_last <= 1'b0;
`endif
            end else begin
                inflight <= issue;
`ifdef RAMZ_READER_LAST_EN
                inflight_last <= last_issue;
`endif
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len != '0) begin
                                state     <= ST_RUN;
                                busy      <= 1'b1;
                                ram_addr  <= base_addr;
                                remaining <= len;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (issue) begin
                            ram_addr  <= ram_addr + 1'b1;
                            remaining <= remaining - 1'b1;
                            if (last_issue) begin
                                state <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_exit) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    ramz_skid_fifo #(
        .W (FW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (pop),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count)
    );

    always_comb begin
        m.m_valid = rd_valid;
        m.m_data  = rd_data[DW-1:0];
`ifdef RAMZ_READER_LAST_EN
        m.m_last  = rd_data[DW];
`endif
    end

endmodule

// File: tb/tb_ramz_reader.sv
// Directed bench for ramz_reader with a 1-cycle registered 128x32 RAM model (mem[i] = A000_0000 + i).
module tb_ramz_reader;
    import ramz_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [6:0]  base_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic [6:0]  ram_addr;
    logic [31:0] ram_rdata;
    logic [31:0] mem [128];

    int n_checks = 0;
    int n_fail   = 0;

    ramz_reader_if #(.DW(RAMZ_DW)) m_if ();

    ramz_reader #(
        .AW (RAMZ_AW),
        .DW (RAMZ_DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .m         (m_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a transfer and consume it; data, order, stalls, done timing checked on the way.
    task automatic run_xfer(input int b, input int n, input bit rnd, input int budget, input bit poke);
        int          k = 0;
        int          first = -1;
        int          last = -1;
        int          dcyc = -1;
        bit          prev_stall = 1'b0;
        bit          busy_seen = 1'b0;
        logic [31:0] prev_data = '0;
        @(negedge clk);
        base_addr   = 7'(b);
        len         = 8'(n);
        start       = 1'b1;
        m_if.m_ready = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            start = poke && (cyc == 4);
            if (poke && cyc == 4) base_addr = 7'(b + 50);
            m_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) check("busy_after_start", 64'(busy), 64'(n != 0));
            if (busy) busy_seen = 1'b1;
            if (prev_stall) begin
                check("stall_valid", 64'(m_if.m_valid), 64'(1));
                check("stall_data", 64'(m_if.m_data), 64'(prev_data));
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                check("word_data", 64'(m_if.m_data), 64'(32'hA000_0000 + 32'((b + k) % 128)));
`ifdef RAMZ_READER_LAST_EN
                check("word_last", 64'(m_if.m_last), 64'(k == n - 1));
`endif
                k++;
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        check("done_seen", 64'(dcyc > 0), 64'(1));
        check("word_count", 64'(k), 64'(n));
        check("busy_end", 64'(busy), 64'(0));
        if (n > 0) begin
            check("done_after_last", 64'(dcyc), 64'(last + 1));
            if (!rnd) begin
                check("first_latency", 64'(first), 64'(3));
                check("throughput", 64'(last - first), 64'(n - 1));
            end
        end else begin
            check("len0_busy_never", 64'(busy_seen), 64'(0));
            check("len0_done_cyc", 64'(dcyc), 64'(1));
        end
        @(negedge clk);
        m_if.m_ready = 1'b1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_no_valid", 64'(m_if.m_valid), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_valid"}, 64'(m_if.m_valid), 64'(0));
        check({tag, "_data"}, 64'(m_if.m_data), 64'(0));
        check({tag, "_addr"}, 64'(ram_addr), 64'(0));
`ifdef RAMZ_READER_LAST_EN
        check({tag, "_last"}, 64'(m_if.m_last), 64'(0));
`endif
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        base_addr    = '0;
        len          = '0;
        m_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        run_xfer(5, 3, 1'b0, 20, 1'b0);
        run_xfer(126, 4, 1'b0, 20, 1'b0);
        run_xfer(9, 1, 1'b0, 20, 1'b0);
        run_xfer(60, 4, 1'b0, 20, 1'b0);
        run_xfer(33, 0, 1'b0, 10, 1'b0);
        run_xfer(0, 128, 1'b0, 200, 1'b0);
        run_xfer(20, 10, 1'b1, 200, 1'b1);

        // abort three cycles into a long transfer
        @(negedge clk);
        base_addr = 7'd0;
        len       = 8'd20;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 64'(m_if.m_valid), 64'(0));
        check("abort_done", 64'(done), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        @(negedge clk);
        check("abort_done_clear", 64'(done), 64'(0));
        run_xfer(40, 2, 1'b0, 20, 1'b0);

        // reset in the middle of a transfer
        @(negedge clk);
        base_addr = 7'd70;
        len       = 8'd20;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_xfer(100, 5, 1'b0, 20, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
